pcg_writer: RTL and testbench

Write-side controller for the 2 KB programmable character generator (PCG) RAM that sits beside the fixed character ROM in the MZ-80A video path. It accepts CPU register writes (address low, address high, pattern data) and queues pattern bytes in a small FIFO. It drains that FIFO into the PCG RAM only while the video generator signals blanking, so pattern writes never collide with display fetches.

---
 rtl/pcg_writer.sv | 141 ++++++++++++++
 tb/tb_pcg_writer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcg_writer.sv
// pcg_writer
// Write-side controller for the MZ-80A programmable character generator RAM.
// CPU register writes set an 11-bit address pointer and enqueue pattern bytes
// (address captured with each byte) into a small FIFO. The FIFO drains into the
// PCG RAM only while the video timing block signals blanking.
//
// Build option: PCG_AUTOINC_EN -- when defined, every accepted data push
// advances the address pointer by one (wrapping 2047 -> 0).
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   cpu_wr    single-cycle CPU write strobe
//   cpu_sel   register select: 0 addr low, 1 addr high, 2 data, 3 ignored
//   cpu_data  CPU write data
//   cpu_busy  FIFO full (registered)
//   ovf       sticky: data write dropped because the FIFO was full
//   blank     early blank; high means the PCG RAM is free next cycle
//   ram_addr  PCG RAM write address (holds last value when idle)
//   ram_din   PCG RAM write data (holds last value when idle)
//   ram_we    PCG RAM write enable, one cycle per byte
module pcg_writer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_sel,
    input  logic [7:0]  cpu_data,
    output logic        cpu_busy,
    output logic        ovf,
    input  logic        blank,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [18:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [10:0]   ptr;

    logic          data_wr;
    logic          push;
    logic          pop;

    // Fullness and emptiness are judged on pre-edge occupancy, so a push
    // into a full FIFO is dropped even if a pop happens on the same edge.
    assign data_wr = cpu_wr && (cpu_sel == 2'd2);
    assign push    = data_wr && (count != FULL);
    assign pop     = blank && (count != '0);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    if (pop) state_next = WRITE;
            WRITE:   if (pop) state_next = WRITE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The write strobe is the state register itself, so reset removes it
    // immediately rather than at the next edge.
    assign ram_we = (state == WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            count    <= '0;
            cpu_busy <= 1'b0;
            ovf      <= 1'b0;
            ptr      <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            count    <= count_next;
            cpu_busy <= (count_next == FULL);
            if (data_wr && (count == FULL)) begin
                ovf <= 1'b1;
            end
            if (push) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx   <= rd_idx + 1'b1;
                ram_addr <= mem[rd_idx][18:8];
                ram_din  <= mem[rd_idx][7:0];
            end
            if (cpu_wr && (cpu_sel == 2'd0)) begin
                ptr[7:0] <= cpu_data;
            end else if (cpu_wr && (cpu_sel == 2'd1)) begin
                ptr[10:8] <= cpu_data[2:0];
            end
`ifdef PCG_AUTOINC_EN
            else if (push) begin
                ptr <= ptr + 11'd1;
            end
`else
`endif
        end
    end

    // Queue storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= {ptr, cpu_data};
        end
    end

endmodule

// File: tb/tb_pcg_writer.sv
module tb_pcg_writer;

    logic        clk;
    logic        rst;
    logic        cpu_wr;
    logic [1:0]  cpu_sel;
    logic [7:0]  cpu_data;
    logic        cpu_busy;
    logic        ovf;
    logic        blank;
    logic [10:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;

    int n_cmp;
    int n_err;

`ifdef PCG_AUTOINC_EN
    localparam logic [10:0] INC = 11'd1;
`else
    localparam logic [10:0] INC = 11'd0;
`endif

    pcg_writer #(.FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_wr   (cpu_wr),
        .cpu_sel  (cpu_sel),
        .cpu_data (cpu_data),
        .cpu_busy (cpu_busy),
        .ovf      (ovf),
        .blank    (blank),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk11(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] data);
        cpu_wr   = 1'b1;
        cpu_sel  = sel;
        cpu_data = data;
        tick();
        cpu_wr   = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [7:0] din, input logic [10:0] addr);
        chk1(tag, ram_we, 1'b1);
        chk8(tag, ram_din, din);
        chk11(tag, ram_addr, addr);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        cpu_wr   = 1'b0;
        cpu_sel  = 2'd0;
        cpu_data = 8'h00;
        blank    = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        chk1("rst_we", ram_we, 1'b0);
        chk11("rst_addr", ram_addr, 11'h000);
        chk8("rst_din", ram_din, 8'h00);
        chk1("rst_busy", cpu_busy, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);

        // Single byte, minimum latency
        wr(2'd0, 8'h23);
        wr(2'd1, 8'h01);
        blank = 1'b1;
        wr(2'd2, 8'hA5);
        chk1("t1_we_n", ram_we, 1'b0);
        tick();
        expect_write("t1_write", 8'hA5, 11'h123);
        tick();
        chk1("t1_we_off", ram_we, 1'b0);
        chk11("t1_addr_hold", ram_addr, 11'h123);
        chk8("t1_din_hold", ram_din, 8'hA5);

        // Fill while not blanked, overflow, then drain
        blank = 1'b0;
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h02);
        wr(2'd2, 8'h10);
        wr(2'd2, 8'h11);
        wr(2'd2, 8'h12);
        chk1("t2_busy3", cpu_busy, 1'b0);
        wr(2'd2, 8'h13);
        chk1("t2_busy4", cpu_busy, 1'b1);
        chk1("t2_no_we", ram_we, 1'b0);
        chk1("t2_ovf0", ovf, 1'b0);
        wr(2'd2, 8'h14);
        chk1("t2_ovf1", ovf, 1'b1);
        chk1("t2_busy5", cpu_busy, 1'b1);
        blank = 1'b1;
        tick();
        expect_write("t2_d0", 8'h10, 11'h200);
        chk1("t2_busy_rel", cpu_busy, 1'b0);
        tick();
        expect_write("t2_d1", 8'h11, 11'h200 + INC);
        tick();
        expect_write("t2_d2", 8'h12, 11'h200 + 11'(2 * INC));
        tick();
        expect_write("t2_d3", 8'h13, 11'h200 + 11'(3 * INC));
        tick();
        chk1("t2_end", ram_we, 1'b0);
        chk1("t2_ovf_sticky", ovf, 1'b1);
        chk1("t2_busy_end", cpu_busy, 1'b0);

        // Blank interrupted mid-drain
        blank = 1'b0;
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h03);
        wr(2'd2, 8'h20);
        wr(2'd2, 8'h21);
        wr(2'd2, 8'h22);
        wr(2'd2, 8'h23);
        blank = 1'b1;
        tick();
        expect_write("t3_d0", 8'h20, 11'h300);
        tick();
        expect_write("t3_d1", 8'h21, 11'h300 + INC);
        blank = 1'b0;
        tick();
        chk1("t3_pause0", ram_we, 1'b0);
        tick();
        chk1("t3_pause1", ram_we, 1'b0);
        blank = 1'b1;
        tick();
        expect_write("t3_d2", 8'h22, 11'h300 + 11'(2 * INC));
        tick();
        expect_write("t3_d3", 8'h23, 11'h300 + 11'(3 * INC));
        tick();
        chk1("t3_end", ram_we, 1'b0);

        // Address wrap / no-autoincrement behaviour
        blank = 1'b0;
        wr(2'd0, 8'hFF);
        wr(2'd1, 8'hFF);
        wr(2'd2, 8'h11);
        wr(2'd2, 8'h22);
        blank = 1'b1;
        tick();
        expect_write("t4_w0", 8'h11, 11'h7FF);
        tick();
        expect_write("t4_w1", 8'h22, 11'h7FF + INC);
        tick();
        chk1("t4_end", ram_we, 1'b0);

        // Simultaneous push and pop
        blank = 1'b0;
        do_reset();
        chk1("t5_ovf_clr", ovf, 1'b0);
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h04);
        wr(2'd2, 8'h30);
        wr(2'd2, 8'h31);
        wr(2'd2, 8'h32);
        blank = 1'b1;
        wr(2'd2, 8'h33);
        expect_write("t5_d0", 8'h30, 11'h400);
        chk1("t5_busy_a", cpu_busy, 1'b0);
        wr(2'd2, 8'h34);
        chk8("t5_d1", ram_din, 8'h31);
        chk1("t5_busy_b", cpu_busy, 1'b0);
        tick();
        chk8("t5_d2", ram_din, 8'h32);
        tick();
        chk8("t5_d3", ram_din, 8'h33);
        tick();
        expect_write("t5_d4", 8'h34, 11'h400 + 11'(4 * INC));
        tick();
        chk1("t5_end", ram_we, 1'b0);
        chk1("t5_ovf_still0", ovf, 1'b0);

        blank = 1'b0;
        wr(2'd2, 8'h40);
        wr(2'd2, 8'h41);
        wr(2'd2, 8'h42);
        wr(2'd2, 8'h43);
        chk1("t5_full", cpu_busy, 1'b1);
        blank = 1'b1;
        wr(2'd2, 8'h44);
        chk8("t5_f0", ram_din, 8'h40);
        chk1("t5_f_ovf", ovf, 1'b1);
        chk1("t5_f_busy", cpu_busy, 1'b0);
        tick();
        chk8("t5_f1", ram_din, 8'h41);
        tick();
        chk8("t5_f2", ram_din, 8'h42);
        tick();
        expect_write("t5_f3", 8'h43, 11'h400 + 11'(8 * INC));
        tick();
        chk1("t5_f_end", ram_we, 1'b0);

        // Reset during a burst
        blank = 1'b0;
        wr(2'd2, 8'h50);
        wr(2'd2, 8'h51);
        wr(2'd2, 8'h52);
        blank = 1'b1;
        tick();
        chk8("t6_d0", ram_din, 8'h50);
        chk1("t6_we", ram_we, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("t6_async_we", ram_we, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk1("t6_busy", cpu_busy, 1'b0);
        chk1("t6_ovf", ovf, 1'b0);
        tick();
        chk1("t6_q0", ram_we, 1'b0);
        tick();
        chk1("t6_q1", ram_we, 1'b0);
        tick();
        chk1("t6_q2", ram_we, 1'b0);
        wr(2'd2, 8'h60);
        chk1("t6_pre", ram_we, 1'b0);
        tick();
        expect_write("t6_new", 8'h60, 11'h000);
        tick();
        chk1("t6_end", ram_we, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
